// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the MEM-stage load/store unit.
// Sub-word support in the users of this package is controlled by the SUBWORD_EN macro.
package mem_access_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{1'b0}};

  // Access size as carried on req_size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // Size/alignment error: illegal size, odd half, or word not on a 4-byte boundary
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// lane_unit: combinational little-endian lane logic for sub-word accesses.
// Load side extracts and extends a byte/half; store side splices a new lane into
// the old word. Only present when SUBWORD_EN is defined.
`ifdef SUBWORD_EN
module lane_unit
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_offset,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_new_data,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte lane and half lane out of the read word
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (i_offset)
      2'b00:   w_byte = i_word[7:0];
      2'b01:   w_byte = i_word[15:8];
      2'b10:   w_byte = i_word[23:16];
      2'b11:   w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_offset[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
  end

  // Zero- or sign-extend the selected lane; words pass through untouched
  always_comb begin
    o_load_data = i_word;
    case (i_size)
      SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Overwrite only the addressed lane of the old word with the new store data
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        case (i_offset)
          2'b00:   o_merged = {i_word[31:8], i_new_data[7:0]};
          2'b01:   o_merged = {i_word[31:16], i_new_data[7:0], i_word[7:0]};
          2'b10:   o_merged = {i_word[31:24], i_new_data[7:0], i_word[15:0]};
          2'b11:   o_merged = {i_new_data[7:0], i_word[23:0]};
          default: o_merged = i_word;
        endcase
      end
      SZ_HALF: begin
        if (i_offset[1]) begin
          o_merged = {i_new_data[15:0], i_word[15:0]};
        end else begin
          o_merged = {i_word[31:16], i_new_data[15:0]};
        end
      end
      default: o_merged = i_new_data;
    endcase
  end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the MEM stage and a word-addressed
// data memory. One request at a time over valid/ready, single-cycle response pulse.
// Define SUBWORD_EN to enable byte/half accesses (read-modify-write for sub-word
// stores); without it only aligned word accesses reach memory and byte/half
// requests complete as errors.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [DATA_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_write_enable,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e            r_state;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  // Write-data register; for sub-word stores it also acts as the merge register
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_accept;
  logic              w_range_err;
  logic              w_size_err;
  logic              w_err;
  logic [DATA_W-1:0] w_word_idx;
  logic [DATA_W-1:0] w_load_data;

  assign w_accept    = i_req_valid & r_req_ready;
  assign w_range_err = |i_req_addr[DATA_W-1:ADDR_W+2];
  assign w_word_idx  = {2'b00, i_req_addr[DATA_W-1:2]};
  assign w_err       = w_size_err | w_range_err;

`ifdef SUBWORD_EN
  logic [1:0]        r_req_size;
  logic [1:0]        r_req_off;
  logic              r_req_signed;
  logic [DATA_W-1:0] r_req_wdata;
  logic [DATA_W-1:0] w_merged;

  assign w_size_err = align_err(i_req_size, i_req_addr[1:0]);

  lane_unit u_lane (
    .i_word      (i_mem_rdata),
    .i_size      (r_req_size),
    .i_offset    (r_req_off),
    .i_signed    (r_req_signed),
    .i_new_data  (r_req_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );
`else
  // Word-only build: anything that is not an aligned word is an error
  logic w_unused_ok;

  assign w_size_err  = (i_req_size != SZ_WORD) | align_err(i_req_size, i_req_addr[1:0]);
  assign w_load_data = i_mem_rdata;
  assign w_unused_ok = i_req_signed;
`endif

  // Request sequencer: accept in IDLE, run the memory access, emit one response
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= ZERO_WORD;
      r_resp_err   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= ZERO_WORD;
      r_mem_wdata  <= ZERO_WORD;
`ifdef SUBWORD_EN
      r_req_size   <= 2'b00;
      r_req_off    <= 2'b00;
      r_req_signed <= 1'b0;
      r_req_wdata  <= ZERO_WORD;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
`ifdef SUBWORD_EN
            r_req_size   <= i_req_size;
            r_req_off    <= i_req_addr[1:0];
            r_req_signed <= i_req_signed;
            r_req_wdata  <= i_req_wdata;
`endif
            if (w_err) begin
              r_state <= ST_ERR;
            end else if (!i_req_write) begin
              r_state    <= ST_LOAD;
              r_mem_addr <= w_word_idx;
            end else if (i_req_size == SZ_WORD) begin
              r_state     <= ST_STORE;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_word_idx;
              r_mem_wdata <= i_req_wdata;
            end else begin
`ifdef SUBWORD_EN
              r_state    <= ST_RMW_RD;
              r_mem_addr <= w_word_idx;
`else
              r_state    <= ST_ERR;
`endif
            end
          end
        end
        ST_LOAD: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_mem_addr   <= ZERO_WORD;
        end
        ST_STORE: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= ZERO_WORD;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= ZERO_WORD;
        end
`ifdef SUBWORD_EN
        ST_RMW_RD: begin
          // Old word is on i_mem_rdata now; keep the merged word for the write cycle
          r_state     <= ST_RMW_WR;
          r_mem_wdata <= w_merged;
          r_mem_we    <= 1'b1;
        end
        ST_RMW_WR: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= ZERO_WORD;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= ZERO_WORD;
        end
`endif
        ST_ERR: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= ZERO_WORD;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= ZERO_WORD;
        end
      endcase
    end
  end

  assign o_req_ready        = r_req_ready;
  assign o_resp_valid       = r_resp_valid;
  assign o_resp_rdata       = r_resp_rdata;
  assign o_resp_err         = r_resp_err;
  // Gate with reset so that a reset edge landing on a write cycle never commits
  assign o_mem_write_enable = r_mem_we & ~i_rst;
  assign o_mem_addr         = r_mem_addr;
  assign o_mem_wdata        = r_mem_wdata;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MIPS MEM stage and the word-addressed data memory. Accepts byte-addressed load/store requests over a valid/ready handshake and drives the memory's write-enable/address/write-data port. It captures the combinational read data and returns a single-cycle response. Sub-word stores are done as read-modify-write because the memory only writes whole words.

## Interface
- ADDR_W, 10, word-index width; memory depth is 2**ADDR_W words
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal size
- mem_write_enable  out  1  memory write strobe
- mem_addr  out  32  word index (req_addr >> 2, zero-extended)
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational memory read data

## Operation
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR.
- IDLE: if req_valid && req_ready at a clock edge, latch the request fields and select the next state:
  - error → ERR
  - load → LOAD
  - word store → STORE
  - sub-word store → RMW_RD
- Error conditions:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - req_addr[31:ADDR_W+2]≠0
- LOAD: drive mem_addr; register the extracted/extended mem_rdata into resp_rdata; go to IDLE.
- STORE: mem_write_enable=1, mem_wdata=latched wdata; go to IDLE.
- RMW_RD: drive mem_addr; register mem_rdata merged with the new lane into a merge register; go to RMW_WR.
- RMW_WR: mem_write_enable=1, mem_wdata=merge register; go to IDLE.
- ERR: no memory access; go to IDLE.
- resp_valid pulses in the cycle after leaving LOAD, STORE, RMW_WR or ERR. resp_err=1 only for ERR.
- Lane mapping is little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k]
  - half h = addr[1] occupies bits [16h+15:16h]
- Load extension: zero-extend unless req_signed=1, in which case sign-extend from bit 7 or bit 15. req_signed is ignored for words.
- mem_addr = 0 and mem_write_enable = 0 in IDLE and ERR.
- A new request may be accepted in the same cycle resp_valid is high.
- Request fields must be held stable while req_valid is high and req_ready is low.

## Timing
- Reset values:
  - state IDLE
  - req_ready 1
  - resp_valid 0, resp_rdata 0, resp_err 0
  - mem_write_enable 0, mem_addr 0, mem_wdata 0
  - latched request and merge register 0
- Accept at edge E0. Response latencies:
  - load/word store/error: resp_valid high in the cycle after E1
  - sub-word store: resp_valid high in the cycle after E2
- Throughput: one word op per 2 cycles; one sub-word store per 3 cycles.
- Memory write commits at the edge ending the STORE or RMW_WR cycle.
- mem_write_enable is combinationally gated by !rst, so a reset edge never commits a write.
- Reset in any state: abandon the operation, no response, IDLE next cycle.

## Configuration
- SUBWORD_EN defined: byte/half loads and stores supported; RMW_RD/RMW_WR and the lane logic are present.
- SUBWORD_EN undefined:
  - size 00/01 is treated as an error (ERR path)
  - RMW states and merge register are absent
  - only word accesses reach memory

## Structure
- Shared package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state enum
  - DATA_W = 32 constant
- One sub-module, lane_unit: purely combinational.
  - Load side: extract lane from word plus signed/zero extension.
  - Store side: merge new lane into old word.
  - Compiled only under SUBWORD_EN.

## Test plan
- Preload mem[2]=9; word load addr 0x08 → resp_valid 2 cycles after accept, resp_rdata=9, resp_err=0, mem_write_enable never high.
- Word store addr 0x0C, wdata 0xDEADBEEF → mem_write_enable high for one cycle with mem_addr=3; a following load of 0x0C returns 0xDEADBEEF.
- SUBWORD_EN, mem[5]=0x00000011:
  - sb addr 0x15, wdata 0xAB → mem[5]=0x0000AB11, response 3 cycles after accept
  - lb signed 0x15 → 0xFFFFFFAB
  - lbu 0x15 → 0x000000AB
- lh addr 0x0B → resp_err=1, resp_rdata=0, no write; word load 0x00001000 with ADDR_W=10 → resp_err=1.
- Assert rst during RMW_WR of sb 0x15 → mem[5] unchanged, no resp_valid, req_ready=1 the cycle after reset releases.
- Without SUBWORD_EN: lb addr 0x08 → resp_err=1 two cycles after accept; memory untouched.
